// File: rtl/uart_pkg.sv
// uart_pkg: shared parity constants, transmitter state type and baud divisor helper.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_e;

    // Returns clock cycles per line bit, or 0 when the divisor is unusable (< 2).
    function automatic int ticks_per_bit(input int clk_hz, input int baud);
        return (baud > 0 && clk_hz / baud >= 2) ? clk_hz / baud : 0;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: single-clock circular FIFO with wrap-bit pointers and first-word fall-through read.
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   push_i, data_i     write strobe and word (ignored while full)
//   pop_i, data_o      read strobe (ignored while empty) and head word
//   full_o, empty_o    status
//   count_o            words held
module uart_fifo #(
    parameter int Width = 8,
    parameter int Depth = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  logic [Width-1:0]       data_i,
    input  logic                   pop_i,
    output logic [Width-1:0]       data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(Depth):0] count_o
);
    localparam int AW = $clog2(Depth);

    if (Depth < 2 || (Depth & (Depth - 1)) != 0) begin : g_bad_depth
        $error("uart_fifo: Depth must be a power of two >= 2");
    end

    logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d;
    logic [Width-1:0] mem_q [Depth];
    logic             do_push, do_pop;

    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty_o = wptr_q == rptr_q;
    assign count_o = wptr_q - rptr_q;
    assign data_o  = mem_q[rptr_q[AW-1:0]];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign wptr_d  = do_push ? wptr_q + (AW+1)'(1) : wptr_q;
    assign rptr_d  = do_pop ? rptr_q + (AW+1)'(1) : rptr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered UART transmitter with configurable data width, parity and stop bits.
//   CLK, RST           clock, asynchronous active-low reset
//   i_valid, i_data    write strobe and word, accepted when o_ready
//   o_ready            FIFO not full
//   o_tx               serial line, idle high
//   o_busy             frame on the line
//   o_count            words queued, excluding the frame in flight
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int ClockFrequency = 50_000_000,
    parameter int BaudRate       = 115200,
    parameter int DataBits       = 8,
    parameter int ParityMode     = 0,
    parameter int StopBits       = 1,
    parameter int FifoDepth      = 16
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       i_valid,
    input  logic [DataBits-1:0]        i_data,
    output logic                       o_ready,
    output logic                       o_tx,
    output logic                       o_busy,
    output logic [$clog2(FifoDepth):0] o_count
);
    localparam int Ticks = ticks_per_bit(ClockFrequency, BaudRate);
    localparam int TW    = $clog2(Ticks);
    localparam int BW    = $clog2(DataBits + 1);
    localparam logic [TW-1:0] TickLast = TW'(Ticks - 1);
    localparam logic [BW-1:0] DataLast = BW'(DataBits - 1);
    localparam logic [BW-1:0] StopLast = BW'(StopBits - 1);

    if (Ticks < 2 || DataBits < 5 || DataBits > 9 || ParityMode < PARITY_NONE ||
        ParityMode > PARITY_ODD || StopBits < 1 || StopBits > 2) begin : g_bad_cfg
        $error("uart_tx_fifo: illegal parameter set");
    end

    uart_state_e         state_q, state_d;
    logic [TW-1:0]       tick_q, tick_d;
    logic [BW-1:0]       bit_q, bit_d;
    logic [DataBits-1:0] shift_q, shift_d, fifo_data;
    logic                par_q, par_d, tx_q, tx_d, busy_q, busy_d;
    logic                pop, full, empty, tick_wrap;

    uart_fifo #(.Width(DataBits), .Depth(FifoDepth)) u_fifo (
        .clk_i  (CLK),
        .rst_ni (RST),
        .push_i (i_valid),
        .data_i (i_data),
        .pop_i  (pop),
        .data_o (fifo_data),
        .full_o (full),
        .empty_o(empty),
        .count_o(o_count)
    );

    assign o_ready   = !full;
    assign o_tx      = tx_q;
    assign o_busy    = busy_q;
    assign tick_wrap = tick_q == TickLast;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        par_d   = par_q;
        pop     = 1'b0;
        case (state_q)
            IDLE:   pop = !empty;
            START:  if (tick_wrap) state_d = DATA;
            DATA: begin
                if (tick_wrap) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == DataLast) state_d = (ParityMode != PARITY_NONE) ? PARITY : STOP;
                end
            end
            PARITY: if (tick_wrap) state_d = STOP;
            STOP: begin
                if (tick_wrap && bit_q == StopLast) begin
                    pop     = !empty;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // A pop from IDLE or from the last stop cycle starts the next frame immediately.
        if (pop) begin
            state_d = START;
            shift_d = fifo_data;
            par_d   = (^fifo_data) ^ (ParityMode == PARITY_ODD);
        end
        tick_d = (state_q == IDLE || tick_wrap) ? '0 : tick_q + TW'(1);
        bit_d  = (state_d != state_q) ? '0 : tick_wrap ? bit_q + BW'(1) : bit_q;
        // Line level is registered from the next state so each bit holds exactly Ticks cycles.
        tx_d   = (state_d == START) ? 1'b0 :
                 (state_d == DATA) ? shift_d[0] :
                 (state_d == PARITY) ? par_d : 1'b1;
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench over six line formats of uart_tx_fifo.
module tb_uart_tx_fifo;
    localparam int TPB = 10;
    localparam int N   = 6;

    typedef struct packed {
        logic [15:0] bits;
        int          n;
    } frame_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid [N];
    logic [8:0] data [N];
    logic       tx_w [N];
    logic       busy_w [N];
    logic       ready_w [N];
    logic [4:0] cnt_w [N];

    frame_t exp_q [$];
    int     n_cmp = 0;
    int     n_bad = 0;
    int     sel = 0;
    bit     abort = 1'b0;

    always #5 clk = ~clk;

    function automatic int db(input int k);
        return k == 3 ? 7 : k == 4 ? 9 : k == 5 ? 5 : 8;
    endfunction

    function automatic int pm(input int k);
        return k == 1 ? 1 : k == 2 ? 2 : k == 3 ? 1 : 0;
    endfunction

    function automatic int sb(input int k);
        return k == 3 ? 2 : 1;
    endfunction

    genvar g;
    for (g = 0; g < N; g++) begin : u
        localparam int D = db(g);
        uart_tx_fifo #(
            .ClockFrequency(1_000_000),
            .BaudRate      (100_000),
            .DataBits      (D),
            .ParityMode    (pm(g)),
            .StopBits      (sb(g)),
            .FifoDepth     (16)
        ) dut (
            .CLK    (clk),
            .RST    (rst_n),
            .i_valid(valid[g]),
            .i_data (data[g][D-1:0]),
            .o_ready(ready_w[g]),
            .o_tx   (tx_w[g]),
            .o_busy (busy_w[g]),
            .o_count(cnt_w[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, got, want);
        end
    endtask

    // Expected line bits, LSB first: start, data, optional parity, stop ones.
    function automatic frame_t mk(input int k, input logic [8:0] w);
        frame_t f;
        logic   p = 1'b0;
        int     d = db(k);
        f.bits = '1;
        f.bits[0] = 1'b0;
        for (int i = 0; i < d; i++) begin
            f.bits[1 + i] = w[i];
            p ^= w[i];
        end
        f.n = 1 + d + sb(k);
        if (pm(k) != 0) begin
            f.bits[1 + d] = (pm(k) == 2) ? ~p : p;
            f.n++;
        end
        return f;
    endfunction

    task automatic wr(input int k, input logic [8:0] w, input bit acc);
        valid[k] = 1'b1;
        data[k] = w;
        if (acc) exp_q.push_back(mk(k, w));
        @(negedge clk);
        valid[k] = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int t = 0;
        while ((exp_q.size() != 0 || busy_w[sel] || !tx_w[sel]) && t < budget) begin
            @(negedge clk);
            t++;
        end
        chk("drain_in_time", 32'(t < budget), 1);
        repeat (3) @(negedge clk);
    endtask

    // Line monitor: each bit of each frame must hold for TPB cycles with busy high.
    initial begin : mon
        frame_t f;
        int     nf = 0;
        int     bad;
        bit     have = 1'b0;
        forever begin
            if (!have) @(negedge clk);
            have = 1'b0;
            if (rst_n && !abort && tx_w[sel] === 1'b0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_start", 1, 0);
                end else begin
                    f = exp_q.pop_front();
                    for (int b = 0; b < f.n && !abort; b++) begin
                        bad = 0;
                        for (int c = 0; c < TPB; c++) begin
                            if (b != 0 || c != 0) @(negedge clk);
                            if (abort) break;
                            if (tx_w[sel] !== f.bits[b] || busy_w[sel] !== 1'b1) bad++;
                        end
                        if (!abort) chk($sformatf("frame%0d_bit%0d_bad_cycles", nf, b), bad, 0);
                    end
                    if (!abort) begin
                        @(negedge clk);
                        have = 1'b1;
                        chk($sformatf("frame%0d_after", nf), {tx_w[sel], busy_w[sel]},
                            exp_q.size() != 0 ? 2'b01 : 2'b10);
                    end
                    nf++;
                end
            end
        end
    end

    initial begin
        for (int k = 0; k < N; k++) begin
            valid[k] = 1'b0;
            data[k] = '0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < N; k++)
            chk($sformatf("reset_vals%0d", k), {tx_w[k], busy_w[k], ready_w[k], cnt_w[k]}, {3'b101, 5'd0});
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 8N1 0xA5 with first-write latency
        sel = 0;
        wr(0, 9'h0A5, 1);
        chk("lat_edgeN", {tx_w[0], busy_w[0], cnt_w[0]}, {2'b10, 5'd1});
        @(negedge clk);
        chk("lat_edgeN1", {tx_w[0], busy_w[0], cnt_w[0]}, {2'b01, 5'd0});
        wait_idle(300);

        // 8E1 / 8O1 0xA5, 7E2 0x7F
        sel = 1;
        wr(1, 9'h0A5, 1);
        wait_idle(300);
        sel = 2;
        wr(2, 9'h0A5, 1);
        wait_idle(300);
        sel = 3;
        wr(3, 9'h07F, 1);
        wait_idle(300);

        // Burst of 17 while busy: 16 stored, 17th dropped
        sel = 0;
        wr(0, 9'h050, 1);
        repeat (4) @(negedge clk);
        for (int i = 0; i < 17; i++) begin
            wr(0, 9'(8'h60 + i), i < 16);
            chk($sformatf("burst_cnt%0d", i), cnt_w[0], i < 16 ? i + 1 : 16);
            chk($sformatf("burst_rdy%0d", i), ready_w[0], 32'(i + 1 < 16));
        end
        wait_idle(2500);

        // Push coinciding with the pop at the end of a frame, count = 3
        wr(0, 9'h011, 1);
        wr(0, 9'h022, 1);
        wr(0, 9'h033, 1);
        wr(0, 9'h044, 1);
        chk("simul_cnt_a", cnt_w[0], 3);
        repeat (97) @(negedge clk);
        chk("simul_cnt_b", cnt_w[0], 3);
        wr(0, 9'h055, 1);
        chk("simul_cnt_c", cnt_w[0], 3);
        wait_idle(700);

        // Reset mid-DATA with 5 words queued
        for (int i = 0; i < 6; i++) wr(0, 9'h000, 1);
        repeat (20) @(negedge clk);
        chk("pre_rst_cnt", cnt_w[0], 5);
        chk("pre_rst_tx", tx_w[0], 0);
        abort = 1'b1;
        #2 rst_n = 1'b0;
        #1 chk("rst_async", {tx_w[0], busy_w[0], ready_w[0], cnt_w[0]}, {3'b101, 5'd0});
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        repeat (3) @(negedge clk);
        abort = 1'b0;
        chk("post_rst_idle", {tx_w[0], busy_w[0], cnt_w[0]}, {2'b10, 5'd0});
        wr(0, 9'h0A5, 1);
        wait_idle(300);

        // 9N1 0x1FF, 5N1 0x15
        sel = 4;
        wr(4, 9'h1FF, 1);
        wait_idle(300);
        sel = 5;
        wr(5, 9'h015, 1);
        wait_idle(300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised, buffered UART transmitter, the successor to the fixed 8N1 simplex transmitter. Configurable data width, parity and stop-bit count; absorbs byte bursts from the frame/pixel logic through an internal FIFO; streams frames back-to-back with exact per-bit timing. FPGA is master; transmit only.

## Interface
- ClockFrequency, 50_000_000: CLK frequency in Hz.
- BaudRate, 115200: line rate. TicksPerBit = ClockFrequency / BaudRate (integer division). TicksPerBit < 2 is an elaboration error.
- DataBits, 8: payload width per frame. Legal values 5..9.
- ParityMode, 0: 0 = none, 1 = even, 2 = odd. Other values are an elaboration error.
- StopBits, 1: 1 or 2.
- FifoDepth, 16: entries. Power of two, ≥ 2.
- CLK  in  1  system clock.
- RST  in  1  asynchronous, active-low reset.
- i_valid  in  1  write strobe; a word is accepted on a CLK edge when i_valid && o_ready.
- i_data  in  DataBits  word to transmit.
- o_ready  out  1  FIFO not full.
- o_tx  out  1  serial line, idle high.
- o_busy  out  1  a frame is on the line (state ≠ IDLE).
- o_count  out  $clog2(FifoDepth)+1  words currently held in the FIFO, excluding the frame in flight.

## Operation
- Frame on the line: start (0), DataBits bits LSB first, optional parity bit, StopBits stop bits (1).
- Parity: even → XOR of data bits; odd → inverted XOR. Computed from the popped word.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: o_tx = 1. If FIFO not empty: pop, load shift register, go to START.
  - START → DATA after TicksPerBit cycles.
  - DATA: shift after each TicksPerBit cycles. After DataBits bits → PARITY if ParityMode ≠ 0, else STOP.
  - PARITY → STOP after TicksPerBit cycles.
  - STOP: after StopBits × TicksPerBit cycles, if FIFO not empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- The tick counter, width $clog2(TicksPerBit), counts 0..TicksPerBit-1 and wraps. The bit counter, width $clog2(DataBits+1), clears on every state entry.
- FIFO: circular buffer with read/write pointers and one extra wrap bit. full = pointers equal with wrap bits differing; empty = pointers fully equal.
- Push while full: ignored, because o_ready = 0. Data is not corrupted.
- Simultaneous push and pop: both take effect; o_count is unchanged.
- Push when full in the same cycle as a pop: not accepted. o_ready reflects the state before the edge.
- Reset asserted at any time, including mid-frame: o_tx = 1 immediately (asynchronously), FIFO emptied, frame in flight abandoned, state = IDLE.

## Timing
- Reset values: o_tx = 1, o_busy = 0, o_ready = 1, o_count = 0.
- o_tx, o_busy and the FSM state are registered. o_ready and o_count are decoded from registered pointers.
- Word written at edge N into an empty FIFO with the FSM in IDLE:
  - pop at edge N+1;
  - o_tx falls and o_busy rises after edge N+1;
  - o_count returns to 0 after edge N+1.
- Every line bit, including the first start bit, lasts exactly TicksPerBit cycles.
- Frame length: (1 + DataBits + (ParityMode≠0) + StopBits) × TicksPerBit cycles.
- Back-to-back frames: the next start bit begins on the cycle after the last stop-bit cycle.
- o_busy falls on the same edge that o_tx enters IDLE.

## Structure
- Shared package uart_pkg holds:
  - parity mode constants: PARITY_NONE/EVEN/ODD;
  - the FSM state typedef;
  - a function computing TicksPerBit and checking its range.
- Sub-module uart_fifo: synchronous single-clock FIFO parametrised by width and depth, with ports for push, pop, full, empty and count. It is reused later on the VGA side.
- The top level contains the FSM, tick counter, bit counter, shift register and parity logic.

## Test plan
Bench parameters: ClockFrequency = 1_000_000, BaudRate = 100_000, so TicksPerBit = 10.
- 8N1, write 0xA5 once → o_tx shows 0,1,0,1,0,0,1,0,1,1, each bit held 10 cycles; the start bit begins 1 cycle after the write; o_busy is high for 100 cycles.
- 8E1 and 8O1, write 0xA5 → parity bit 0 (even) and 1 (odd); frame is 110 cycles; 7E2 with 0x7F → parity 1, two stop bits, frame is 110 cycles.
- Burst of 17 writes into a depth-16 FIFO while the line is busy → o_ready falls after the 16th stored word; the 17th write is dropped; 16 frames follow with no idle gaps and correct data order.
- Simultaneous push and pop with count = 3 → count stays 3; pushed data appears in order.
- RST pulsed low mid-DATA with 5 words queued → o_tx = 1 within the same cycle; o_count = 0, o_busy = 0; the next write transmits a clean frame.
- 9N1 with 0x1FF and 5N1 with 0x15 → correct bit count and LSB-first order; frames are 110 and 70 cycles.
